// File: rtl/fc_infer_sched.sv
// fc_infer_sched: collects feature vectors into a two-bank buffer and replays
// each complete vector to fc_softmax_unit as one burst. It then tracks the score
// stream and the class result, and holds one result per vector for downstream.
//
// state | meaning
// IDLE  | waiting for bank[rd_bank] to fill
// FEED  | streaming bank[rd_bank] to the FC unit, one byte per cycle
// WAIT  | collecting scores/class; watchdog running
// HOLD  | result presented on res_*, waiting for res_ready
module fc_infer_sched #(
  parameter int IN_DIM  = 32,
  parameter int OUT_DIM = 10,
  parameter int CLS_W   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       feat_data,
  input  logic             feat_valid,
  input  logic             feat_last,
  output logic             feat_ready,
  output logic [7:0]       fc_in_data,
  output logic             fc_in_valid,
  input  logic [31:0]      fc_out_data,
  input  logic             fc_out_valid,
  input  logic [CLS_W-1:0] fc_class_out,
  input  logic             fc_class_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CLS_W-1:0] res_class,
  output logic [31:0]      res_score,
  output logic [1:0]       res_err,
  output logic             stat_len_err,
  output logic             busy
);

  localparam int AW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SC_W0 = $clog2(OUT_DIM + 1) + 1;
  localparam int SC_W  = (SC_W0 > CLS_W) ? SC_W0 : CLS_W;

  localparam logic [AW-1:0]   LAST_A  = AW'(IN_DIM - 1);
  localparam logic [AW-1:0]   A_ONE   = AW'(1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0] SC_MAX  = '1;
  localparam logic [SC_W-1:0] OUT_N   = SC_W'(OUT_DIM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        full_q;
  logic              wr_bank_q, rd_bank_q;
  logic [AW-1:0]     wr_cnt_q, rd_cnt_q;
  logic [7:0]        mem [2][IN_DIM];
  logic              ready_en_q;
  logic              len_err_q;
  logic              fc_in_valid_q;
  logic [7:0]        fc_in_data_q;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [31:0]       max_q, max_d;
  logic [CLS_W-1:0]  arg_q, arg_d;
  logic [WD_W-1:0]   wd_q;
  logic [CLS_W-1:0]  res_class_q;
  logic [31:0]       res_score_q;
  logic [1:0]        res_err_q;

  logic feat_acc, feed_start, feed_done, wait_st, score_hit;

  // ready_en_q keeps feat_ready low while reset is asserted and releases it on
  // the first clock afterwards, so every output reads 0 during reset.
  assign feat_ready = ready_en_q & ~full_q[wr_bank_q];
  assign feat_acc   = feat_valid & feat_ready;
  assign feed_start = (state_q == ST_IDLE) & full_q[rd_bank_q];
  assign feed_done  = (state_q == ST_FEED) & (rd_cnt_q == LAST_A);
  assign wait_st    = (state_q == ST_WAIT);
  assign score_hit  = wait_st & fc_out_valid;

  // Next-state logic for the feed/result sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (full_q[rd_bank_q]) state_d = ST_FEED;
      ST_FEED: if (rd_cnt_q == LAST_A) state_d = ST_WAIT;
      ST_WAIT: if (fc_class_valid || (wd_q == '0)) state_d = ST_HOLD;
      ST_HOLD: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Running max/argmax including the score arriving this cycle, so a class
  // pulse coincident with the last score still sees the complete stream.
  always_comb begin
    sc_d  = sc_q;
    max_d = max_q;
    arg_d = arg_q;
    if (score_hit) begin
      if ((sc_q == '0) || ($signed(fc_out_data) > $signed(max_q))) begin
        max_d = fc_out_data;
        arg_d = sc_q[CLS_W-1:0];
      end
      if (sc_q != SC_MAX) sc_d = sc_q + SC_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Bank bookkeeping: fill on the load side, free on the last feed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      len_err_q  <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (feat_acc) begin
        if (wr_cnt_q == LAST_A) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
          wr_cnt_q          <= '0;
        end else if (feat_last) begin
          wr_cnt_q  <= '0;
          len_err_q <= 1'b1;
        end else begin
          wr_cnt_q <= wr_cnt_q + A_ONE;
        end
      end
      // The bank being freed is always full, the one being filled always
      // empty, so these never touch the same bit.
      if (feed_done) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
    end
  end

  // Feature storage; contents of a dropped or reset frame are simply ignored.
  always_ff @(posedge clk) begin
    if (feat_acc) mem[wr_bank_q][wr_cnt_q] <= feat_data;
  end

  // Registered feed outputs; rd_cnt_q is the index currently on fc_in_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_in_valid_q <= 1'b0;
      fc_in_data_q  <= 8'h00;
      rd_cnt_q      <= '0;
    end else if (feed_start) begin
      fc_in_valid_q <= 1'b1;
      fc_in_data_q  <= mem[rd_bank_q][0];
      rd_cnt_q      <= '0;
    end else if (state_q == ST_FEED) begin
      if (rd_cnt_q == LAST_A) begin
        fc_in_valid_q <= 1'b0;
        fc_in_data_q  <= 8'h00;
        rd_cnt_q      <= '0;
      end else begin
        fc_in_data_q <= mem[rd_bank_q][rd_cnt_q + A_ONE];
        rd_cnt_q     <= rd_cnt_q + A_ONE;
      end
    end
  end

  // Score tracking, watchdog down-counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q        <= '0;
      max_q       <= '0;
      arg_q       <= '0;
      wd_q        <= '0;
      res_class_q <= '0;
      res_score_q <= '0;
      res_err_q   <= 2'b00;
    end else if (feed_done) begin
      sc_q  <= '0;
      max_q <= '0;
      arg_q <= '0;
      wd_q  <= WD_LOAD;
    end else if (wait_st) begin
      sc_q  <= sc_d;
      max_q <= max_d;
      arg_q <= arg_d;
      if (wd_q != '0) wd_q <= wd_q - WD_ONE;
      if (fc_class_valid) begin
        res_class_q <= fc_class_out;
        res_score_q <= max_d;
        res_err_q   <= {1'b0, (sc_d != OUT_N) || (fc_class_out != arg_d)};
      end else if (wd_q == '0) begin
        res_class_q <= '0;
        res_score_q <= '0;
        res_err_q   <= 2'b10;
      end
    end
  end

  assign fc_in_valid  = fc_in_valid_q;
  assign fc_in_data   = fc_in_data_q;
  assign res_valid    = (state_q == ST_HOLD);
  assign res_class    = res_class_q;
  assign res_score    = res_score_q;
  assign res_err      = res_err_q;
  assign stat_len_err = len_err_q;
  assign busy         = (|full_q) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_fc_infer_sched.sv
// Directed bench for fc_infer_sched with a simple FC responder model.
module tb_fc_infer_sched;

  localparam int IN_DIM  = 32;
  localparam int OUT_DIM = 10;
  localparam int CLS_W   = 4;
  localparam int TIMEOUT = 256;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       feat_data;
  logic             feat_valid;
  logic             feat_last;
  logic             feat_ready;
  logic [7:0]       fc_in_data;
  logic             fc_in_valid;
  logic [31:0]      fc_out_data;
  logic             fc_out_valid;
  logic [CLS_W-1:0] fc_class_out;
  logic             fc_class_valid;
  logic             res_valid;
  logic             res_ready;
  logic [CLS_W-1:0] res_class;
  logic [31:0]      res_score;
  logic [1:0]       res_err;
  logic             stat_len_err;
  logic             busy;

  fc_infer_sched #(
    .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .CLS_W(CLS_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .feat_data(feat_data), .feat_valid(feat_valid), .feat_last(feat_last),
    .feat_ready(feat_ready),
    .fc_in_data(fc_in_data), .fc_in_valid(fc_in_valid),
    .fc_out_data(fc_out_data), .fc_out_valid(fc_out_valid),
    .fc_class_out(fc_class_out), .fc_class_valid(fc_class_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_score(res_score), .res_err(res_err),
    .stat_len_err(stat_len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int hs_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Burst monitor: start cycle, length and data of every fc_in_valid run.
  int          start_q[$];
  int          len_q[$];
  logic [7:0]  fed_q[$];
  logic        mon_prev = 1'b0;
  int          mon_len = 0;
  int          idle_data_bad = 0;

  initial forever begin
    @(negedge clk);
    if (fc_in_valid) begin
      if (!mon_prev) begin
        start_q.push_back(cyc);
        mon_len = 0;
      end
      fed_q.push_back(fc_in_data);
      mon_len++;
    end else begin
      if (mon_prev) len_q.push_back(mon_len);
      if (fc_in_data != 8'h00) idle_data_bad++;
    end
    mon_prev = fc_in_valid;
  end

  // FC responder: 3 cycles after a burst ends, stream model_n scores then class.
  logic [31:0]      model_scores [OUT_DIM];
  int               model_n = OUT_DIM;
  logic [CLS_W-1:0] model_class = '0;
  logic             model_cls_en = 1'b1;
  logic             model_prev = 1'b0;

  initial begin
    fc_out_valid = 1'b0; fc_out_data = '0; fc_class_valid = 1'b0; fc_class_out = '0;
    forever begin
      @(posedge clk); #1;
      if (model_prev && !fc_in_valid && rst_n) begin
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < model_n; i++) begin
          fc_out_valid = 1'b1; fc_out_data = model_scores[i];
          @(posedge clk); #1;
        end
        fc_out_valid = 1'b0; fc_out_data = '0;
        if (model_cls_en) begin
          fc_class_valid = 1'b1; fc_class_out = model_class;
          @(posedge clk); #1;
          fc_class_valid = 1'b0; fc_class_out = '0;
        end
      end
      model_prev = fc_in_valid;
    end
  end

  task automatic set_scores(input int s0, s1, s2, s3, s4, s5, s6, s7, s8, s9,
                            input logic [CLS_W-1:0] cls);
    model_scores[0] = s0; model_scores[1] = s1; model_scores[2] = s2;
    model_scores[3] = s3; model_scores[4] = s4; model_scores[5] = s5;
    model_scores[6] = s6; model_scores[7] = s7; model_scores[8] = s8;
    model_scores[9] = s9; model_class = cls;
  endtask

  // Called at posedge+1; leaves at posedge+1 after the last byte is accepted.
  task automatic send_frame(input int n, input int base, input int last_idx, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      feat_valid = 1'b1; feat_data = 8'(base + i); feat_last = (i == last_idx);
      for (int b = 0; b < 2000 && !feat_ready; b++) begin
        stalls++;
        @(posedge clk); #1;
      end
      if (!feat_ready) check_val("feat_ready_wait", 32'(feat_ready), 1);
      last_acc = cyc;
      @(posedge clk); #1;
    end
    feat_valid = 1'b0; feat_last = 1'b0; feat_data = '0;
  endtask

  task automatic check_burst(input string tag, input int base, input int exp_len, input int exp_start);
    int s, l, bad;
    logic [7:0] d;
    for (int b = 0; b < 1000 && len_q.size() == 0; b++) begin @(posedge clk); #1; end
    check_val({tag, "_seen"}, 32'(len_q.size() > 0), 1);
    if (len_q.size() == 0) return;
    s = start_q.pop_front();
    l = len_q.pop_front();
    check_val({tag, "_start"}, s, exp_start);
    check_val({tag, "_len"}, l, exp_len);
    bad = 0;
    for (int i = 0; i < l; i++) begin
      d = fed_q.pop_front();
      if (d != 8'(base + i)) bad++;
    end
    check_val({tag, "_data"}, bad, 0);
  endtask

  task automatic take_result(input string tag, input logic [CLS_W-1:0] e_cls,
                             input logic [31:0] e_score, input logic [1:0] e_err);
    for (int b = 0; b < 1000 && !res_valid; b++) begin @(posedge clk); #1; end
    check_val({tag, "_valid"}, 32'(res_valid), 1);
    check_val({tag, "_class"}, 32'(res_class), 32'(e_cls));
    check_val({tag, "_score"}, res_score, e_score);
    check_val({tag, "_err"}, 32'(res_err), 32'(e_err));
    res_ready = 1'b1; hs_cyc = cyc;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_val({tag, "_drop"}, 32'(res_valid), 0);
  endtask

  initial begin
    int st, a_end, hold_cyc, s, rv_cyc;
    feat_valid = 1'b0; feat_last = 1'b0; feat_data = '0; res_ready = 1'b0;
    set_scores(5, -3, 90, 7, 1, 2, -50, 0, 89, 3, 4'd2);

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_feat_ready", 32'(feat_ready), 0);
    check_val("rst_fc_in_valid", 32'(fc_in_valid), 0);
    check_val("rst_res_valid", 32'(res_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_len_err", 32'(stat_len_err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_ready", 32'(feat_ready), 1);

    // Single frame, bytes 1..32, class 2, max 90.
    send_frame(32, 1, 31, st);
    check_burst("t1", 1, 32, last_acc + 2);
    take_result("t1", 4'd2, 32'd90, 2'b00);

    // Back-to-back frames with res_ready held low. Frame 1's bank is freed
    // at the end of its feed, so frame 3 still fits; after it both banks are full.
    send_frame(32, 100, 31, st);
    a_end = last_acc;
    send_frame(32, 150, 31, st);
    check_val("t2_f2_stalls", st, 0);
    check_burst("t2_f1", 100, 32, a_end + 2);
    for (int b = 0; b < 1000 && !res_valid; b++) begin @(posedge clk); #1; end
    check_val("t2_hold_seen", 32'(res_valid), 1);
    hold_cyc = cyc;
    send_frame(32, 200, 31, st);
    check_val("t2_f3_stalls", st, 0);
    check_val("t2_full_ready", 32'(feat_ready), 0);
    check_val("t2_full_busy", 32'(busy), 1);
    while (cyc < hold_cyc + 200) begin @(posedge clk); #1; end
    check_val("t2_hold_valid", 32'(res_valid), 1);
    check_val("t2_no_feed", start_q.size(), 0);
    take_result("t2_f1", 4'd2, 32'd90, 2'b00);
    check_burst("t2_f2", 150, 32, hs_cyc + 2);
    take_result("t2_f2", 4'd2, 32'd90, 2'b00);
    check_burst("t2_f3", 200, 32, hs_cyc + 2);
    take_result("t2_f3", 4'd2, 32'd90, 2'b00);

    // Early feat_last on byte 10: dropped, no feed, sticky error.
    send_frame(10, 40, 9, st);
    check_val("t3_len_err", 32'(stat_len_err), 1);
    repeat (40) @(posedge clk);
    #1;
    check_val("t3_no_feed", start_q.size(), 0);
    check_val("t3_busy", 32'(busy), 0);
    check_val("t3_ready", 32'(feat_ready), 1);
    send_frame(32, 60, 31, st);
    check_burst("t3", 60, 32, last_acc + 2);
    take_result("t3", 4'd2, 32'd90, 2'b00);

    // Watchdog: WAIT runs TIMEOUT cycles after the 32-cycle feed.
    model_cls_en = 1'b0;
    send_frame(32, 10, 31, st);
    s = last_acc + 2;
    check_burst("t4", 10, 32, s);
    for (int b = 0; b < 1000 && !res_valid; b++) begin @(posedge clk); #1; end
    rv_cyc = cyc;
    check_val("t4_latency", rv_cyc, s + 31 + 1 + TIMEOUT);
    take_result("t4", 4'd0, 32'd0, 2'b10);
    model_cls_en = 1'b1;

    // Ties at indices 3 and 7: lowest index is the internal argmax.
    set_scores(1, 2, 3, 1000, 5, 6, 7, 1000, -1, 0, 4'd7);
    send_frame(32, 70, 31, st);
    check_burst("t5a", 70, 32, last_acc + 2);
    take_result("t5a", 4'd7, 32'd1000, 2'b01);
    set_scores(1, 2, 3, 1000, 5, 6, 7, 1000, -1, 0, 4'd3);
    send_frame(32, 70, 31, st);
    check_burst("t5b", 70, 32, last_acc + 2);
    take_result("t5b", 4'd3, 32'd1000, 2'b00);

    // All-negative scores: first score loads the max, signed compare.
    set_scores(-10, -5, -7, -9, -100, -6, -8, -20, -30, -40, 4'd1);
    send_frame(32, 90, 31, st);
    check_burst("t5c", 90, 32, last_acc + 2);
    take_result("t5c", 4'd1, 32'hFFFF_FFFB, 2'b00);

    // Short score stream (9 of 10) flags a mismatch.
    set_scores(5, -3, 90, 7, 1, 2, -50, 0, 89, 3, 4'd2);
    model_n = 9;
    send_frame(32, 5, 31, st);
    check_burst("t5d", 5, 32, last_acc + 2);
    take_result("t5d", 4'd2, 32'd90, 2'b01);
    model_n = OUT_DIM;

    // Reset asserted mid-cycle during FEED cycle 15.
    send_frame(32, 1, 31, st);
    s = last_acc + 2;
    while (cyc < s + 15) begin @(posedge clk); #1; end
    #1;
    rst_n = 1'b0;
    #1;
    check_val("t6_fc_in_valid", 32'(fc_in_valid), 0);
    check_val("t6_fc_in_data", 32'(fc_in_data), 0);
    check_val("t6_busy", 32'(busy), 0);
    check_val("t6_res_valid", 32'(res_valid), 0);
    check_val("t6_feat_ready", 32'(feat_ready), 0);
    check_val("t6_len_err", 32'(stat_len_err), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_burst("t6_cut", 1, 15, s);
    send_frame(32, 1, 31, st);
    check_burst("t6", 1, 32, last_acc + 2);
    take_result("t6", 4'd2, 32'd90, 2'b00);

    check_val("idle_data_zero", idle_data_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d limit reached", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
